mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/wb_mux.sv | 18 +
 rtl/mem_wb_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pipe_pkg : shared pipeline widths, WB bit indices and entry type   |
// | Revision : 1.0                                                     |
// +-------------------------------------------------------------------+
package pipe_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int REG_W_DEF    = 5;
  localparam int WB_W_DEF     = 2;
  localparam int REGWRITE_BIT = 1;
  localparam int MEMTOREG_BIT = 0;

  typedef struct packed {
    logic [WB_W_DEF-1:0]   wb;
    logic [REG_W_DEF-1:0]  rd;
    logic [DATA_W_DEF-1:0] alu;
    logic [DATA_W_DEF-1:0] rdata;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | wb_mux : MemToReg select between memory read data and ALU result   |
// | Revision : 1.0                                                     |
// +-------------------------------------------------------------------+
module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              i_memtoreg,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_alu,
  output logic [DATA_W-1:0] o_data
);

  assign o_data = i_memtoreg ? i_rdata : i_alu;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_wb_stage : two-entry MEM/WB skid register with WB forwarding   |
// | Revision : 1.0                                                     |
// +-------------------------------------------------------------------+
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int WB_W   = WB_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [WB_W-1:0]   in_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [DATA_W-1:0] out_alu,
  output logic [REG_W-1:0]  out_rd,
  output logic [WB_W-1:0]   out_wb,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occ
);

  wb_entry_t r_head;
  wb_entry_t r_skid;
  logic      r_head_v;
  logic      r_skid_v;
  wb_entry_t w_in;
  logic      w_acc;
  logic      w_con;

  assign w_in.rdata = in_rdata;
  assign w_in.alu   = in_alu;
  assign w_in.rd    = in_rd;
  assign w_in.wb    = in_wb;

  // Ready depends only on the skid flag, so out_ready never reaches in_ready.
  assign in_ready = ~r_skid_v & ~rst;
  assign w_acc    = in_valid & in_ready;
  assign w_con    = r_head_v & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_skid   <= '0;
      r_head_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (flush) begin
      r_head_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_con) begin
      if (r_skid_v) begin
        r_head   <= r_skid;
        r_skid_v <= w_acc;
        if (w_acc) r_skid <= w_in;
      end else if (w_acc) begin
        r_head <= w_in;
      end else begin
        r_head_v <= 1'b0;
      end
    end else if (w_acc) begin
      if (r_head_v) begin
        r_skid   <= w_in;
        r_skid_v <= 1'b1;
      end else begin
        r_head   <= w_in;
        r_head_v <= 1'b1;
      end
    end
  end

  assign out_valid = r_head_v;
  assign out_rdata = r_head.rdata;
  assign out_alu   = r_head.alu;
  assign out_rd    = r_head.rd;
  assign out_wb    = r_head_v ? r_head.wb : '0;
  assign fwd_valid = r_head_v & out_wb[REGWRITE_BIT];
  assign fwd_rd    = r_head.rd;
  assign occ       = {1'b0, r_head_v} + {1'b0, r_skid_v};

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .i_memtoreg (out_wb[MEMTOREG_BIT]),
    .i_rdata    (r_head.rdata),
    .i_alu      (r_head.alu),
    .o_data     (fwd_data)
  );

endmodule
`default_nettype wire
